// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the hazard/forwarding slice.
// Holds the opcode encodings and the per-stage producer record.
package riscv_pkg;

    typedef enum logic [6:0] {
        OPC_OP     = 7'b0110011,
        OPC_OP_IMM = 7'b0010011,
        OPC_LOAD   = 7'b0000011,
        OPC_STORE  = 7'b0100011,
        OPC_BRANCH = 7'b1100011,
        OPC_JAL    = 7'b1101111,
        OPC_JALR   = 7'b1100111,
        OPC_LUI    = 7'b0110111,
        OPC_AUIPC  = 7'b0010111
    } opcode_e;

    typedef struct packed {
        logic       valid;
        logic       we;
        logic       is_load;
        logic [4:0] rd;
    } slot_t;

    localparam slot_t SLOT_BUBBLE = '0;

    // x0 is hard-wired to zero, so a producer targeting it never creates a dependency.
    function automatic logic slot_match(input slot_t s, input logic [4:0] rs);
        return s.valid && s.we && (s.rd != 5'd0) && (s.rd == rs);
    endfunction

endpackage

// File: rtl/riscv_inst_decode_lite.sv
// Minimal RV32 decoder: register fields plus write/load/source-use flags.
// Only the opcode is inspected; funct bits never change hazard behaviour.
module riscv_inst_decode_lite
    import riscv_pkg::*;
(
    input  logic [31:0] inst,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic        we,
    output logic        is_load,
    output logic        use_rs1,
    output logic        use_rs2
);

    logic [6:0] opcode;
    logic       unused_bits;

    assign opcode      = inst[6:0];
    assign rd          = inst[11:7];
    assign rs1         = inst[19:15];
    assign rs2         = inst[24:20];
    assign unused_bits = ^{inst[31:25], inst[14:12]};

    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    always_comb begin
        we      = 1'b0;
        is_load = 1'b0;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        case (opcode)
            OPC_OP: begin
                we      = 1'b1;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_OP_IMM: begin
                we      = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_LOAD: begin
                we      = 1'b1;
                is_load = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_STORE, OPC_BRANCH: begin
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
            end
            OPC_JALR: begin
                we      = 1'b1;
                use_rs1 = 1'b1;
            end
            OPC_JAL, OPC_LUI, OPC_AUIPC: begin
                we = 1'b1;
            end
            default: begin
                we = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/riscv_hazard_fwd_unit.sv
// RAW hazard detection and operand-forward selection for an in-order pipeline.
// Tracks DEPTH producer stages after decode; outputs are combinational from decode.
module riscv_hazard_fwd_unit
    import riscv_pkg::*;
#(
    parameter  int DEPTH  = 3,
    parameter  int FWD_EN = 1,
    parameter  int CNT_W  = 16,
    localparam int SEL_W  = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      inst_id,
    input  logic             inst_valid_id,
    input  logic             freeze,
    input  logic             flush,
    output logic [SEL_W-1:0] forward_a,
    output logic [SEL_W-1:0] forward_b,
    output logic             stall_id,
    output logic [CNT_W-1:0] stall_cnt
);

    slot_t            slot_q [DEPTH];
    slot_t            slot_d [DEPTH];
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;

    logic [4:0] id_rd;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_we;
    logic       id_is_load;
    logic       id_use_rs1;
    logic       id_use_rs2;
    slot_t      id_slot;

    riscv_inst_decode_lite u_decode (
        .inst    (inst_id),
        .rd      (id_rd),
        .rs1     (id_rs1),
        .rs2     (id_rs2),
        .we      (id_we),
        .is_load (id_is_load),
        .use_rs1 (id_use_rs1),
        .use_rs2 (id_use_rs2)
    );

    assign id_slot = '{valid: 1'b1, we: id_we, is_load: id_is_load, rd: id_rd};

    logic [DEPTH-1:0] hit_a;
    logic [DEPTH-1:0] hit_b;

    always_comb begin
        hit_a = '0;
        hit_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            hit_a[k] = id_use_rs1 && slot_match(slot_q[k], id_rs1);
            hit_b[k] = id_use_rs2 && slot_match(slot_q[k], id_rs2);
        end
    end

    // Walk oldest to youngest so the youngest matching producer wins; load data is
    // not yet available in EX, so a load in slot 0 is never a forward source.
    always_comb begin
        forward_a = '0;
        forward_b = '0;
        if (FWD_EN != 0) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (hit_a[k] && !(k == 0 && slot_q[0].is_load)) forward_a = SEL_W'(k + 1);
                if (hit_b[k] && !(k == 0 && slot_q[0].is_load)) forward_b = SEL_W'(k + 1);
            end
        end
    end

    logic load_use;
    logic any_raw;
    logic stall_raw;

    assign load_use  = slot_q[0].is_load && (hit_a[0] || hit_b[0]);
    assign any_raw   = |(hit_a | hit_b);
    assign stall_raw = (FWD_EN != 0) ? load_use : any_raw;
    assign stall_id  = stall_raw && inst_valid_id && !flush;

    always_comb begin
        slot_d      = slot_q;
        stall_cnt_d = stall_cnt_q;
        if (!freeze) begin
            for (int i = 1; i < DEPTH; i++) begin
                slot_d[i] = slot_q[i-1];
            end
            slot_d[0] = (flush || stall_id || !inst_valid_id) ? SLOT_BUBBLE : id_slot;
            if (stall_id && (stall_cnt_q != '1)) begin
                stall_cnt_d = stall_cnt_q + 1'b1;
            end
        end
    end

    // NOTE: the slot array is reset because its valid bits gate every match; stale
    // entries after reset would otherwise raise phantom hazards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= SLOT_BUBBLE;
            end
            stall_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            slot_q      <= slot_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_fwd_unit.sv
// Directed scoreboard bench for riscv_hazard_fwd_unit: forwarding instance plus a
// no-forwarding instance with a 2-bit stall counter.
module tb_riscv_hazard_fwd_unit;

    logic clk;
    logic rst_n;

    logic [31:0] inst_a, inst_b;
    logic        valid_a, valid_b;
    logic        freeze_a, freeze_b;
    logic        flush_a, flush_b;
    logic [1:0]  fa_a, fb_a, fa_b, fb_b;
    logic        st_a, st_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    riscv_hazard_fwd_unit u_dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_id       (inst_a),
        .inst_valid_id (valid_a),
        .freeze        (freeze_a),
        .flush         (flush_a),
        .forward_a     (fa_a),
        .forward_b     (fb_a),
        .stall_id      (st_a),
        .stall_cnt     (cnt_a)
    );

    riscv_hazard_fwd_unit #(.DEPTH(3), .FWD_EN(0), .CNT_W(2)) u_dut_nf (
        .clk           (clk),
        .rst_n         (rst_n),
        .inst_id       (inst_b),
        .inst_valid_id (valid_b),
        .freeze        (freeze_b),
        .flush         (flush_b),
        .forward_a     (fa_b),
        .forward_b     (fb_b),
        .stall_id      (st_b),
        .stall_cnt     (cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        string       tag;
        int          dut;
        logic [1:0]  fa;
        logic [1:0]  fb;
        logic        st;
        logic [31:0] cnt;
    } exp_t;

    exp_t   sb_q[$];
    int     vectors    = 0;
    int     miscompares = 0;
    int     model_cnt [2] = '{0, 0};
    int     cnt_max   [2] = '{65535, 3};
    bit     pend_inc  [2] = '{1'b0, 1'b0};

    function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_i(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'd0, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm, rs1, 3'b010, rd, 7'b0000011};
    endfunction

    function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [4:0] rs1, input logic [11:0] imm);
        return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one decode-cycle, queue its expectation, then compare mid-cycle.
    task automatic drive_check(input int d, input string tag, input logic [31:0] inst,
                               input logic v, input logic fl, input logic fz,
                               input logic [1:0] efa, input logic [1:0] efb, input logic est);
        exp_t e;
        exp_t got;
        if (d == 0) begin
            inst_a = inst; valid_a = v; flush_a = fl; freeze_a = fz;
            inst_b = '0;   valid_b = 1'b0; flush_b = 1'b0; freeze_b = 1'b0;
        end else begin
            inst_b = inst; valid_b = v; flush_b = fl; freeze_b = fz;
            inst_a = '0;   valid_a = 1'b0; flush_a = 1'b0; freeze_a = 1'b0;
        end
        e.tag = tag; e.dut = d; e.fa = efa; e.fb = efb; e.st = est;
        e.cnt = model_cnt[d];
        sb_q.push_back(e);
        pend_inc[d] = est && !fz;
        #4;
        got = sb_q.pop_front();
        if (got.dut == 0) begin
            check({got.tag, ".fwd_a"}, 32'(fa_a), 32'(got.fa));
            check({got.tag, ".fwd_b"}, 32'(fb_a), 32'(got.fb));
            check({got.tag, ".stall"}, 32'(st_a), 32'(got.st));
            check({got.tag, ".cnt"},   32'(cnt_a), got.cnt);
        end else begin
            check({got.tag, ".fwd_a"}, 32'(fa_b), 32'(got.fa));
            check({got.tag, ".fwd_b"}, 32'(fb_b), 32'(got.fb));
            check({got.tag, ".stall"}, 32'(st_b), 32'(got.st));
            check({got.tag, ".cnt"},   32'(cnt_b), got.cnt);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        for (int d = 0; d < 2; d++) begin
            if (pend_inc[d] && model_cnt[d] < cnt_max[d]) model_cnt[d]++;
            pend_inc[d] = 1'b0;
        end
        #1;
    endtask

    task automatic step(input int d, input string tag, input logic [31:0] inst,
                        input logic v, input logic fl, input logic fz,
                        input logic [1:0] efa, input logic [1:0] efb, input logic est);
        drive_check(d, tag, inst, v, fl, fz, efa, efb, est);
        tick();
    endtask

    initial begin
        rst_n = 1'b0;
        inst_a = '0; valid_a = 1'b0; flush_a = 1'b0; freeze_a = 1'b0;
        inst_b = '0; valid_b = 1'b0; flush_b = 1'b0; freeze_b = 1'b0;
        @(posedge clk);
        #1;
        inst_a = enc_r(5'd8, 5'd7, 5'd7); valid_a = 1'b1;
        #1;
        check("reset.fwd_a", 32'(fa_a), 32'd0);
        check("reset.stall", 32'(st_a), 32'd0);
        check("reset.cnt",   32'(cnt_a), 32'd0);
        check("reset_nf.cnt", 32'(cnt_b), 32'd0);
        rst_n = 1'b1;
        tick();

        // Single-cycle ALU forwarding from EX.
        step(0, "alu_prod",  enc_r(5'd5, 5'd1, 5'd2), 1, 0, 0, 2'd0, 2'd0, 0);
        step(0, "alu_fwd",   enc_r(5'd6, 5'd5, 5'd3), 1, 0, 0, 2'd1, 2'd0, 0);
        // Load-use: one bubble, then both operands from MEM.
        step(0, "lw_prod",   enc_lw(5'd7, 5'd1, 12'd0), 1, 0, 0, 2'd0, 2'd0, 0);
        step(0, "lu_stall",  enc_r(5'd8, 5'd7, 5'd7), 1, 0, 0, 2'd0, 2'd0, 1);
        step(0, "lu_fwd",    enc_r(5'd8, 5'd7, 5'd7), 1, 0, 0, 2'd2, 2'd2, 0);
        // x0 producer never matches.
        step(0, "x0_prod",   enc_i(5'd0, 5'd1, 12'd5), 1, 0, 0, 2'd0, 2'd0, 0);
        step(0, "x0_store",  enc_sw(5'd0, 5'd2, 12'd4), 1, 0, 0, 2'd0, 2'd0, 0);
        // x9 in slot0 and slot2: youngest wins.
        step(0, "x9_old",    enc_i(5'd9, 5'd0, 12'd1), 1, 0, 0, 2'd0, 2'd0, 0);
        step(0, "x10_mid",   enc_i(5'd10, 5'd0, 12'd0), 1, 0, 0, 2'd0, 2'd0, 0);
        step(0, "x9_new",    enc_i(5'd9, 5'd9, 12'd1), 1, 0, 0, 2'd2, 2'd0, 0);
        step(0, "x9_young",  enc_r(5'd11, 5'd9, 5'd0), 1, 0, 0, 2'd1, 2'd0, 0);
        // Flush kills the load-use stall and inserts a bubble.
        step(0, "fl_lw",     enc_lw(5'd7, 5'd1, 12'd0), 1, 0, 0, 2'd0, 2'd0, 0);
        step(0, "fl_use",    enc_r(5'd8, 5'd7, 5'd7), 1, 1, 0, 2'd0, 2'd0, 0);
        step(0, "fl_after",  enc_r(5'd8, 5'd7, 5'd7), 1, 0, 0, 2'd2, 2'd2, 0);
        // Freeze holds slots and counter.
        step(0, "fz_lw",     enc_lw(5'd7, 5'd1, 12'd0), 1, 0, 0, 2'd0, 2'd0, 0);
        step(0, "fz_hold",   enc_r(5'd8, 5'd7, 5'd7), 1, 0, 1, 2'd0, 2'd0, 1);
        step(0, "fz_stall",  enc_r(5'd8, 5'd7, 5'd7), 1, 0, 0, 2'd0, 2'd0, 1);
        step(0, "fz_fwd",    enc_r(5'd8, 5'd7, 5'd7), 1, 0, 0, 2'd2, 2'd2, 0);
        // Reset asserted mid-stall discards the hazard.
        step(0, "rs_lw",     enc_lw(5'd7, 5'd1, 12'd0), 1, 0, 0, 2'd0, 2'd0, 0);
        drive_check(0, "rs_stall", enc_r(5'd8, 5'd7, 5'd7), 1, 0, 0, 2'd0, 2'd0, 1);
        rst_n = 1'b0;
        #1;
        check("rs_async.stall", 32'(st_a), 32'd0);
        check("rs_async.cnt",   32'(cnt_a), 32'd0);
        model_cnt[0] = 0; model_cnt[1] = 0;
        pend_inc[0] = 1'b0; pend_inc[1] = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, "rs_after",  enc_r(5'd8, 5'd7, 5'd7), 1, 0, 0, 2'd0, 2'd0, 0);

        // No-forwarding instance: stall for the whole producer lifetime, 2-bit saturation.
        step(1, "nf_prod",   enc_r(5'd5, 5'd1, 5'd2), 1, 0, 0, 2'd0, 2'd0, 0);
        step(1, "nf_st0",    enc_r(5'd6, 5'd5, 5'd3), 1, 0, 0, 2'd0, 2'd0, 1);
        step(1, "nf_st1",    enc_r(5'd6, 5'd5, 5'd3), 1, 0, 0, 2'd0, 2'd0, 1);
        step(1, "nf_st2",    enc_r(5'd6, 5'd5, 5'd3), 1, 0, 0, 2'd0, 2'd0, 1);
        step(1, "nf_go",     enc_r(5'd6, 5'd5, 5'd3), 1, 0, 0, 2'd0, 2'd0, 0);
        step(1, "nf_sat0",   enc_r(5'd12, 5'd6, 5'd6), 1, 0, 0, 2'd0, 2'd0, 1);
        step(1, "nf_sat1",   enc_r(5'd12, 5'd6, 5'd6), 1, 0, 0, 2'd0, 2'd0, 1);
        step(1, "nf_sat2",   enc_r(5'd12, 5'd6, 5'd6), 1, 0, 0, 2'd0, 2'd0, 1);
        step(1, "nf_done",   enc_r(5'd12, 5'd6, 5'd6), 1, 0, 0, 2'd0, 2'd0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/riscv_hazard_fwd_unit.md
RISCV_HAZARD_FWD_UNIT -- requirements
Module: riscv_hazard_fwd_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 3, meaning number of tracked producer stages after decode (slot0=EX, slot1=MEM, slot2=WB); legal 2..6.
REQ-002 SHALL have parameter FWD_EN, default 1, meaning 1=forward plus load-use stall, 0=no forwarding, stall on any RAW hazard.
REQ-003 SHALL have parameter CNT_W, default 16, meaning width of the stall performance counter.
REQ-004 SHALL have localparam SEL_W = clog2(DEPTH+1), meaning forward-select width.
REQ-005 SHALL have ports: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-006 SHALL have ports: inst_id input 32, instruction in decode (s2); inst_valid_id input 1, inst_id is real.
REQ-007 SHALL have ports: freeze input 1, whole-pipeline hold; flush input 1, kill decode instruction (taken branch/jump).
REQ-008 SHALL have ports: forward_a output SEL_W, rs1 source; forward_b output SEL_W, rs2 source; 0=regfile, k=slot k-1.
REQ-009 SHALL have ports: stall_id output 1, hold IF/ID and insert bubble into EX; stall_cnt output CNT_W, saturating stall-cycle count.

Function
REQ-010 SHALL decode opcodes: writes rd = R(0110011), I-ALU(0010011), LOAD(0000011), JAL(1101111), JALR(1100111), LUI(0110111), AUIPC(0010111).
REQ-011 SHALL treat rs1 as used for R, I-ALU, LOAD, STORE(0100011), BRANCH(1100011), JALR; rs2 as used for R, STORE, BRANCH only.
REQ-012 SHALL hold per slot {valid, we, is_load, rd[4:0]}; a slot with rd=0 SHALL never match.
REQ-013 SHALL, per edge when freeze=0, shift slot[i] <= slot[i-1] for i=1..DEPTH-1; slot[0] <= bubble if flush, stall_id or !inst_valid_id, else decoded inst_id.
REQ-014 SHALL hold all slots and stall_cnt unchanged while freeze=1.
REQ-015 SHALL, FWD_EN=1, set forward_x = k+1 for the lowest k whose slot is valid, we=1, rd equals the used rs; else 0.
REQ-016 SHALL, FWD_EN=1, assert stall_id when slot0 is a valid load whose rd matches a used nonzero rs of a valid inst_id; forward from slot0 is then suppressed (0 or older match).
REQ-017 SHALL, FWD_EN=0, drive forward_a/forward_b = 0 and assert stall_id when any valid slot with we=1 matches a used nonzero rs.
REQ-018 SHALL force stall_id=0 when flush=1 or inst_valid_id=0; flush dominates stall.
REQ-019 SHALL keep forward_a/forward_b/stall_id purely combinational from inst_id and slots (zero latency).
REQ-020 SHALL increment stall_cnt each edge with stall_id=1 and freeze=0, saturating at all-ones (no wrap).
REQ-021 SHALL apply priority rst_n > freeze > flush > stall > normal shift.

Reset
REQ-022 SHALL, on rst_n=0, asynchronously clear all slot valid/we/is_load/rd and stall_cnt to 0, so forward_a=forward_b=0 and stall_id=0.
REQ-023 SHALL, when reset is asserted mid-stall, discard the pending hazard; first post-reset instruction sees empty slots.

Structure
REQ-024 SHALL place opcode constants and the slot record typedef in shared package riscv_pkg.
REQ-025 SHALL use one sub-module riscv_inst_decode_lite (inst -> rd, rs1, rs2, we, is_load, use_rs1, use_rs2), instanced for inst_id.

Verification
REQ-026 SHALL cover add x5,x1,x2 then add x6,x5,x3 next cycle -> forward_a=1, forward_b=0, stall_id=0.
REQ-027 SHALL cover lw x7,0(x1) then add x8,x7,x7 -> stall_id=1 one cycle, stall_cnt=1, then forward_a=forward_b=2.
REQ-028 SHALL cover addi x0,x1,5 then sw x0,4(x2) -> forward_b=0, no stall.
REQ-029 SHALL cover x9 written in slot0 and slot2 simultaneously, consumer reads x9 -> forward_a=1 (youngest wins).
REQ-030 SHALL cover load-use hazard with flush=1 same cycle -> stall_id=0, slot0 bubble next cycle; with freeze=1 -> slots and stall_cnt hold.
REQ-031 SHALL cover FWD_EN=0, DEPTH=3: add x5 then dependent add -> stall_id=1 for 3 cycles, forward_a=0 throughout; CNT_W=2 saturates at 3.
